// File: rtl/alu_load_ctrl.sv
// rtl/alu_load_ctrl.sv - debounced operand/opcode loader with registered ALU
//
// Purpose: synchronises and debounces three load buttons, latches operand A,
// operand B and the opcode from the switch bus on clean press edges, and
// presents a registered ALU result with status flags.
//
// Ports:
//   clk            single clock
//   btn_Reset      synchronous active-high reset
//   pulsador[2:0]  asynchronous load buttons: [0] A, [1] B, [2] opcode
//   entrada        switch bus (operand, or opcode in entrada[COD_OP-1:0])
//   ALU_Out        registered result
//   flag_zero      result is zero (valid opcodes only)
//   flag_carry     ADD carry-out / SUB borrow
//   flag_overflow  signed overflow for ADD/SUB
//   op_error       latched opcode is unsupported
//   loaded[2:0]    register loaded since reset, same order as pulsador
//   result_valid   ALU_Out reflects a computation with all registers loaded
module alu_load_ctrl #(
  parameter int NBITS    = 8,
  parameter int COD_OP   = 6,
  parameter int DEBOUNCE = 16
) (
  input  logic              clk,
  input  logic              btn_Reset,
  input  logic [2:0]        pulsador,
  input  logic [NBITS-1:0]  entrada,
  output logic [NBITS-1:0]  ALU_Out,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              flag_overflow,
  output logic              op_error,
  output logic [2:0]        loaded,
  output logic              result_valid
);

  localparam int CW = $clog2(DEBOUNCE);
  localparam logic [CW-1:0]     CNT_LAST    = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0]     CNT_ONE     = CW'(1);
  localparam logic [NBITS-1:0]  SHIFT_LIMIT = NBITS'(NBITS);

  localparam logic [COD_OP-1:0] OP_ADD = COD_OP'(6'b100000);
  localparam logic [COD_OP-1:0] OP_SUB = COD_OP'(6'b100010);
  localparam logic [COD_OP-1:0] OP_AND = COD_OP'(6'b100100);
  localparam logic [COD_OP-1:0] OP_OR  = COD_OP'(6'b100101);
  localparam logic [COD_OP-1:0] OP_XOR = COD_OP'(6'b100110);
  localparam logic [COD_OP-1:0] OP_NOR = COD_OP'(6'b100111);
  localparam logic [COD_OP-1:0] OP_SRL = COD_OP'(6'b000010);
  localparam logic [COD_OP-1:0] OP_SRA = COD_OP'(6'b000011);

  logic [2:0]        sync_a;
  logic [2:0]        sync_b;
  logic [2:0]        level;
  logic [2:0]        level_d;
  logic [CW-1:0]     cnt [3];
  logic [2:0]        strobe;
  logic [NBITS-1:0]  reg_a;
  logic [NBITS-1:0]  reg_b;
  logic [COD_OP-1:0] reg_op;
  logic              compute;

  logic [NBITS:0]    sum;
  logic [NBITS:0]    diff;
  logic [NBITS-1:0]  alu_res;
  logic              alu_c;
  logic              alu_v;
  logic              alu_err;

  // Press edge of the debounced level; releases are ignored.
  assign strobe = level & ~level_d;

  // Button path: two-flop synchroniser, then a counter that must see
  // DEBOUNCE consecutive disagreeing samples before the level flips.
  always_ff @(posedge clk) begin
    if (btn_Reset) begin
      sync_a  <= '0;
      sync_b  <= '0;
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync_a  <= pulsador;
      sync_b  <= sync_a;
      level_d <= level;
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]   <= '0;
          level[i] <= ~level[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    sum     = {1'b0, reg_a} + {1'b0, reg_b};
    diff    = {1'b0, reg_a} - {1'b0, reg_b};
    case (reg_op)
      OP_ADD: begin
        alu_res = sum[NBITS-1:0];
        alu_c   = sum[NBITS];
        alu_v   = (reg_a[NBITS-1] == reg_b[NBITS-1]) &&
                  (sum[NBITS-1] != reg_a[NBITS-1]);
      end
      OP_SUB: begin
        // The extra top bit of the zero-extended difference is the borrow.
        alu_res = diff[NBITS-1:0];
        alu_c   = diff[NBITS];
        alu_v   = (reg_a[NBITS-1] != reg_b[NBITS-1]) &&
                  (diff[NBITS-1] != reg_a[NBITS-1]);
      end
      OP_AND: alu_res = reg_a & reg_b;
      OP_OR:  alu_res = reg_a | reg_b;
      OP_XOR: alu_res = reg_a ^ reg_b;
      OP_NOR: alu_res = ~(reg_a | reg_b);
      OP_SRL: alu_res = (reg_b >= SHIFT_LIMIT) ? '0 : (reg_a >> reg_b);
      OP_SRA: alu_res = (reg_b >= SHIFT_LIMIT) ? {NBITS{reg_a[NBITS-1]}}
                                               : ($signed(reg_a) >>> reg_b);
      default: alu_err = 1'b1;
    endcase
  end

  // Load registers on strobes; a strobe that leaves all three loaded arms a
  // recompute on the following edge from the freshly loaded values.
  always_ff @(posedge clk) begin
    if (btn_Reset) begin
      reg_a         <= '0;
      reg_b         <= '0;
      reg_op        <= '0;
      loaded        <= '0;
      compute       <= 1'b0;
      ALU_Out       <= '0;
      flag_zero     <= 1'b0;
      flag_carry    <= 1'b0;
      flag_overflow <= 1'b0;
      op_error      <= 1'b0;
      result_valid  <= 1'b0;
    end else begin
      if (strobe[0]) reg_a  <= entrada;
      if (strobe[1]) reg_b  <= entrada;
      if (strobe[2]) reg_op <= entrada[COD_OP-1:0];
      loaded  <= loaded | strobe;
      compute <= (strobe != 3'b000) && ((loaded | strobe) == 3'b111);
      if (compute) begin
        ALU_Out       <= alu_res;
        flag_zero     <= !alu_err && (alu_res == '0);
        flag_carry    <= alu_c;
        flag_overflow <= alu_v;
        op_error      <= alu_err;
        result_valid  <= 1'b1;
      end
    end
  end

endmodule
